// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types, defaults and helpers for the LED pattern driver
// Contents:
//   led_mode_t     channel mode encoding (OFF, ON, BLINK, PWM)
//   DEF_*          default parameter values
//   addr_width()   channel address width (at least 1 bit)
//   clamp_index()  saturates a BLINK bit index to the top counter bit
package led_pattern_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int MODE_W         = 2;
    localparam int DEF_NUM_LEDS   = 4;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_PRESCALE_W = 16;
    localparam int DEF_DUTY_W     = 8;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_index(input int raw, input int max_idx);
        return (raw > max_idx) ? max_idx : raw;
    endfunction

endpackage

// File: rtl/led_pattern_driver_channel.sv
// rtl/led_pattern_driver_channel.sv - one LED channel: mode/param registers and registered LED bit
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en          accepted config write addressed to this channel
//   wr_mode        new mode
//   wr_param       BLINK bit index (low bits) or PWM duty
//   counter, tick  shared timebase and its advance strobe
//   led            registered LED drive, active-high
// Build option: LED_BREATHE_EN adds a per-channel ramp so PWM channels breathe.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  led_mode_t         wr_mode,
    input  logic [DUTY_W-1:0] wr_param,
    input  logic [CNT_W-1:0]  counter,
    input  logic              tick,
    output logic              led
);
    localparam int IDX_W = $clog2(CNT_W);

    led_mode_t         mode_q, mode_d;
    logic [DUTY_W-1:0] param_q, param_d;
    logic              led_q, led_d;
    logic [DUTY_W-1:0] eff_duty;
    logic [IDX_W-1:0]  wr_idx;

`ifdef LED_BREATHE_EN
    localparam logic [DUTY_W-1:0] DUTY_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};
    logic [DUTY_W-1:0] ramp_q, ramp_d;
    logic              dir_q, dir_d;   // 1 = ramping up
    logic              wrap;
`else
    logic              unused_tick;
    assign unused_tick = tick;
`endif

    always_comb begin
        // BLINK index is clamped once at write time so the read side never indexes past the counter
        wr_idx  = IDX_W'(clamp_index(int'(wr_param[IDX_W-1:0]), CNT_W - 1));
        mode_d  = mode_q;
        param_d = param_q;
        if (wr_en) begin
            mode_d  = wr_mode;
            param_d = (wr_mode == LED_BLINK) ? DUTY_W'(wr_idx) : wr_param;
        end

`ifdef LED_BREATHE_EN
        // Phase wrap: the counter's low DUTY_W bits roll over on this tick
        wrap   = tick && (counter[DUTY_W-1:0] == '1);
        ramp_d = ramp_q;
        dir_d  = dir_q;
        if (wr_en) begin
            ramp_d = '0;
            dir_d  = 1'b1;
        end else if ((mode_q == LED_PWM) && wrap) begin
            if (param_q == '0) begin
                ramp_d = '0;
                dir_d  = 1'b1;
            end else if (dir_q) begin
                if (ramp_q < param_q) begin
                    ramp_d = ramp_q + DUTY_ONE;
                end else begin
                    ramp_d = ramp_q - DUTY_ONE;
                    dir_d  = 1'b0;
                end
            end else begin
                if (ramp_q != '0) begin
                    ramp_d = ramp_q - DUTY_ONE;
                end else begin
                    ramp_d = ramp_q + DUTY_ONE;
                    dir_d  = 1'b1;
                end
            end
        end
        eff_duty = ramp_q;
`else
        eff_duty = param_q;
`endif

        case (mode_q)
            LED_OFF:   led_d = 1'b0;
            LED_ON:    led_d = 1'b1;
            LED_BLINK: led_d = counter[param_q[IDX_W-1:0]];
            LED_PWM:   led_d = (counter[DUTY_W-1:0] < eff_duty);
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= LED_OFF;
            param_q <= '0;
            led_q   <= 1'b0;
`ifdef LED_BREATHE_EN
            ramp_q  <= '0;
            dir_q   <= 1'b1;
`endif
        end else begin
            mode_q  <= mode_d;
            param_q <= param_d;
            led_q   <= led_d;
`ifdef LED_BREATHE_EN
            ramp_q  <= ramp_d;
            dir_q   <= dir_d;
`endif
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pattern_driver.sv
// rtl/led_pattern_driver.sv - multi-channel LED driver with shared prescaler and timebase counter
// Ports:
//   Clock, Reset   clock, synchronous active-high reset
//   Prescale       tick period minus 1 (0 = tick every cycle)
//   CfgValid/CfgReady/CfgAddr/CfgMode/CfgParam   channel config write handshake
//   Tick           one-cycle pulse per prescaler period
//   Counter        timebase counter, advances once per Tick
//   LED            registered LED drives, active-high
// Build option: LED_BREATHE_EN (handled in led_channel) makes PWM channels breathe.
module led_pattern_driver
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS   = DEF_NUM_LEDS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DUTY_W     = DEF_DUTY_W,
    localparam int ADDR_W    = addr_width(NUM_LEDS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  CfgValid,
    output logic                  CfgReady,
    input  logic [ADDR_W-1:0]     CfgAddr,
    input  logic [MODE_W-1:0]     CfgMode,
    input  logic [DUTY_W-1:0]     CfgParam,
    output logic                  Tick,
    output logic [CNT_W-1:0]      Counter,
    output logic [NUM_LEDS-1:0]   LED
);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic                  tick_q, tick_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic                  ready_q, ready_d;
    logic                  cfg_accept;
    logic [NUM_LEDS-1:0]   ch_wr;

    always_comb begin
        // >= rather than == so lowering Prescale below the running count wraps at once
        tick_d    = (pre_cnt_q >= Prescale);
        pre_cnt_d = tick_d ? '0 : (pre_cnt_q + PRE_ONE);
        counter_d = tick_q ? (counter_q + CNT_ONE) : counter_q;
        ready_d   = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            counter_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
            counter_q <= counter_d;
            ready_q   <= ready_d;
        end
    end

    assign cfg_accept = CfgValid && ready_q;

    // Out-of-range addresses match no channel, so the write is accepted and dropped
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        assign ch_wr[i] = cfg_accept && (CfgAddr == ADDR_W'(i));

        led_channel #(
            .CNT_W  (CNT_W),
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk      (Clock),
            .rst      (Reset),
            .wr_en    (ch_wr[i]),
            .wr_mode  (led_mode_t'(CfgMode)),
            .wr_param (CfgParam),
            .counter  (counter_q),
            .tick     (tick_q),
            .led      (LED[i])
        );
    end

    assign CfgReady = ready_q;
    assign Tick     = tick_q;
    assign Counter  = counter_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// tb/tb_led_pattern_driver.sv - self-checking bench for led_pattern_driver (default build)
module tb_led_pattern_driver;
    import led_pattern_pkg::*;

    localparam int NL = 3;
    localparam int CW = 10;
    localparam int PW = 16;
    localparam int DW = 8;
    localparam int AW = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [PW-1:0] Prescale;
    logic          CfgValid;
    logic          CfgReady;
    logic [AW-1:0] CfgAddr;
    logic [1:0]    CfgMode;
    logic [DW-1:0] CfgParam;
    logic          Tick;
    logic [CW-1:0] Counter;
    logic [NL-1:0] LED;

    always #5 Clock = ~Clock;

    led_pattern_driver #(
        .NUM_LEDS   (NL),
        .CNT_W      (CW),
        .PRESCALE_W (PW),
        .DUTY_W     (DW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Prescale (Prescale),
        .CfgValid (CfgValid),
        .CfgReady (CfgReady),
        .CfgAddr  (CfgAddr),
        .CfgMode  (CfgMode),
        .CfgParam (CfgParam),
        .Tick     (Tick),
        .Counter  (Counter),
        .LED      (LED)
    );

    typedef struct {
        logic [AW-1:0] addr;
        led_mode_t     mode;
        logic [DW-1:0] param;
        logic [NL-1:0] exp_led;
    } vec_t;

    vec_t          tbl[9];
    logic [NL-1:0] exp_q[$];
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            n = 0;
    int            cnt_err = 0;
    int            b2_err = 0;
    int            b1_err = 0;
    int            ch1_from = 0;
    int            pwm_high = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    endtask

    task automatic clk1();
        @(posedge Clock);
        #1;
        n++;
    endtask

    task automatic do_reset(input logic [PW-1:0] p);
        Reset    = 1'b1;
        Prescale = p;
        CfgValid = 1'b0;
        CfgAddr  = '0;
        CfgMode  = '0;
        CfgParam = '0;
        repeat (3) clk1();
        Reset = 1'b0;
        n = 0;
    endtask

    function automatic logic blink2_exp(input int nn);
        logic [CW-1:0] e;
        e = CW'(nn - 2);
        return e[1];
    endfunction

    // One cycle with Prescale=0: Counter after edge n is n-1, LED reflects the counter one edge earlier
    task automatic track();
        logic [CW-1:0] ec, ep;
        clk1();
        ec = CW'(n - 1);
        ep = CW'(n - 2);
        if (Counter !== ec) cnt_err++;
        if (n == 1024) check("counter_top", Counter, 1023);
        if (n == 1025) check("counter_wrap", Counter, 0);
        if (LED[2] !== ep[1]) b2_err++;
        if ((ch1_from > 0) && (n >= ch1_from) && (LED[1] !== ep[9])) b1_err++;
        if (LED[0]) pwm_high++;
    endtask

    task automatic wr_track(input logic [AW-1:0] a, input led_mode_t m, input logic [DW-1:0] p);
        CfgValid = 1'b1;
        CfgAddr  = a;
        CfgMode  = m;
        CfgParam = p;
        track();
        CfgValid = 1'b0;
    endtask

    task automatic pwm_window(input logic [DW-1:0] duty, input int exp_high, input string name);
        wr_track(2'd0, LED_PWM, duty);
        track();
        pwm_high = 0;
        repeat (256) track();
        check(name, pwm_high, exp_high);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            ticks;
        int            tick_n[8];
        logic [NL-1:0] prev;

        tbl[0] = '{2'd0, LED_ON,    8'd0,   3'b001};
        tbl[1] = '{2'd1, LED_ON,    8'd0,   3'b011};
        tbl[2] = '{2'd3, LED_ON,    8'd0,   3'b011};
        tbl[3] = '{2'd2, LED_PWM,   8'd5,   3'b111};
        tbl[4] = '{2'd0, LED_PWM,   8'd0,   3'b110};
        tbl[5] = '{2'd1, LED_BLINK, 8'd3,   3'b100};
        tbl[6] = '{2'd2, LED_OFF,   8'd0,   3'b000};
        tbl[7] = '{2'd1, LED_ON,    8'd0,   3'b010};
        tbl[8] = '{2'd0, LED_PWM,   8'd255, 3'b011};

        // Reset values, then first cycle after release
        Reset    = 1'b1;
        Prescale = 16'd3;
        CfgValid = 1'b0;
        CfgAddr  = '0;
        CfgMode  = '0;
        CfgParam = '0;
        repeat (3) clk1();
        check("rst_led", LED, 0);
        check("rst_counter", Counter, 0);
        check("rst_tick", Tick, 0);
        check("rst_ready", CfgReady, 0);
        Reset = 1'b0;
        n = 0;
        clk1();
        check("post_ready", CfgReady, 1);
        check("post_tick", Tick, 0);
        check("post_counter", Counter, 0);
        check("post_led", LED, 0);

        // Prescale=3: tick every 4th cycle
        ticks = 0;
        for (int c = 0; c < 64 && ticks < 8; c++) begin
            clk1();
            if (Tick) begin
                tick_n[ticks] = n;
                ticks++;
            end
        end
        check("tick_count", ticks, 8);
        for (int k = 0; k < ticks; k++) check("tick_spacing", tick_n[k], 4 * (k + 1));
        clk1();
        check("counter_after_8", Counter, 8);
        Prescale = 16'd0;
        for (int k = 0; k < 8; k++) begin
            clk1();
            check("tick_fast", Tick, 1);
        end
        check("counter_fast", Counter, 15);

        // Table: frozen timebase, write latency via scoreboard
        do_reset(16'hFFFF);
        clk1();
        prev = '0;
        for (int i = 0; i < 9; i++) begin
            CfgValid = 1'b1;
            CfgAddr  = tbl[i].addr;
            CfgMode  = tbl[i].mode;
            CfgParam = tbl[i].param;
            exp_q.push_back(prev);
            exp_q.push_back(tbl[i].exp_led);
            clk1();
            CfgValid = 1'b0;
            check("tbl_ready", CfgReady, 1);
            check("tbl_hold", LED, exp_q.pop_front());
            clk1();
            check("tbl_new", LED, exp_q.pop_front());
            prev = tbl[i].exp_led;
        end

        // BLINK idx=1 on ch2, Prescale=0
        do_reset(16'd0);
        clk1();
        wr_track(2'd2, LED_BLINK, 8'd1);
        check("blink_latency", LED[2], 0);
        for (int k = 0; k < 16; k++) begin
            track();
            check("blink_ch2", LED[2], blink2_exp(n));
        end

        // Clamped BLINK index (15 -> 9) on ch1, PWM duty windows on ch0, counter wrap
        wr_track(2'd1, LED_BLINK, 8'd15);
        ch1_from = n + 2;
        pwm_window(8'd64, 64, "pwm_64");
        pwm_window(8'd0, 0, "pwm_0");
        pwm_window(8'd255, 255, "pwm_255");
        while (n < 1040) track();
        check("counter_track", cnt_err, 0);
        check("blink_ch2_track", b2_err, 0);
        check("blink_clamp_ch1", b1_err, 0);

        // Reset mid-operation
        Reset = 1'b1;
        clk1();
        check("mid_rst_led", LED, 0);
        check("mid_rst_counter", Counter, 0);
        check("mid_rst_tick", Tick, 0);
        check("mid_rst_ready", CfgReady, 0);
        Reset = 1'b0;
        clk1();
        check("mid_post_ready", CfgReady, 1);
        repeat (4) clk1();
        check("mid_post_led", LED, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
